// File: rtl/nasti_lite_pkg.sv
// nasti_lite_pkg
//   Shared definitions for the NASTI-Lite initiator:
//     - NASTI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//     - state_e, the transaction FSM state encoding
package nasti_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/nasti_lite_watchdog.sv
// nasti_lite_watchdog
//   Response-wait counter. It is compiled only when NASTI_LITE_MASTER_TIMEOUT_EN
//   is defined, because only then does the master instantiate it.
//   The counter is held at zero while clear is high and increments while
//   enable is high. expire is high while the count equals TIMEOUT-1.
// Ports
//   clk     in   clock
//   rstn    in   asynchronous active-low reset
//   clear   in   force the count to zero
//   enable  in   advance the count
//   expire  out  count has reached TIMEOUT-1
`ifdef NASTI_LITE_MASTER_TIMEOUT_EN
module nasti_lite_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/nasti_lite_master.sv
// nasti_lite_master
//   Single-outstanding NASTI-Lite initiator. A command (write or read) is
//   turned into an AW/W/B or AR/R transaction, and the result is returned
//   on a response handshake. All outputs come from flops.
// Configuration
//   NASTI_LITE_MASTER_TIMEOUT_EN: when defined, a response that does not
//   arrive within TIMEOUT cycles completes with DECERR. In this build
//   b_ready and r_ready are also held high in IDLE, so that late beats
//   are drained.
// Ports
//   clk, rstn                         clock, asynchronous active-low reset
//   cmd_*                             command handshake
//                                     (write flag, addr, wdata, strb)
//   rsp_*                             response handshake (rdata, resp)
//   aw_*, w_*, b_*, ar_*, r_*         NASTI-Lite initiator channels
module nasti_lite_master
    import nasti_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ID         = 0,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [ID_WIDTH-1:0]     aw_id,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic [2:0]              aw_prot,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [ID_WIDTH-1:0]     b_id,
    input  logic [1:0]              b_resp,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [ID_WIDTH-1:0]     ar_id,
    output logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic [2:0]              ar_prot,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [ID_WIDTH-1:0]     r_id,
    input  logic [DATA_WIDTH-1:0]   r_data,
    input  logic [1:0]              r_resp
);

    localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(ID);

    state_e                  state_q,     state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    aw_valid_q,  aw_valid_d;
    logic                    w_valid_q,   w_valid_d;
    logic                    ar_valid_q,  ar_valid_d;
    logic                    b_ready_q,   b_ready_d;
    logic                    r_ready_q,   r_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [DATA_WIDTH/8-1:0] strb_q,      strb_d;
    logic                    timeout_hit;

`ifdef NASTI_LITE_MASTER_TIMEOUT_EN
    // The counter is cleared outside the response-wait states, so it
    // always starts from zero on entry to WR_RESP or RD_RESP.
    logic wait_state;
    assign wait_state = (state_q == WR_RESP) || (state_q == RD_RESP);

    nasti_lite_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (!wait_state),
        .enable (wait_state),
        .expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    strb_d  = cmd_strb;
                    if (cmd_write) begin
                        state_d    = WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD_REQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently. Once a channel's valid
                // has dropped, any further ready on it has no effect.
                if (aw_ready) aw_valid_d = 1'b0;
                if (w_ready)  w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (b_valid && b_ready_q) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = (b_id != MY_ID) ? RESP_SLVERR : b_resp;
                end else if (timeout_hit) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_DECERR;
                end
            end
            RD_REQ: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_valid && r_ready_q) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = r_data;
                    rsp_resp_d  = (r_id != MY_ID) ? RESP_SLVERR : r_resp;
                end else if (timeout_hit) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_DECERR;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The ready outputs are derived from the next state so that they
        // are registered and line up with the state they belong to.
        cmd_ready_d = (state_d == IDLE);
`ifdef NASTI_LITE_MASTER_TIMEOUT_EN
        b_ready_d = (state_d == WR_RESP) || (state_d == IDLE);
        r_ready_d = (state_d == RD_RESP) || (state_d == IDLE);
`else
        b_ready_d = (state_d == WR_RESP);
        r_ready_d = (state_d == RD_RESP);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            b_ready_q   <= b_ready_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign aw_valid  = aw_valid_q;
    assign aw_id     = MY_ID;
    assign aw_addr   = addr_q;
    assign aw_prot   = 3'b000;
    assign w_valid   = w_valid_q;
    assign w_data    = wdata_q;
    assign w_strb    = strb_q;
    assign b_ready   = b_ready_q;
    assign ar_valid  = ar_valid_q;
    assign ar_id     = MY_ID;
    assign ar_addr   = addr_q;
    assign ar_prot   = 3'b000;
    assign r_ready   = r_ready_q;

endmodule

// File: tb/tb_nasti_lite_master.sv
// tb_nasti_lite_master
//   Directed bench for nasti_lite_master. The bench itself acts as the
//   command source, the response sink and the NASTI-Lite responder.
//   When NASTI_LITE_MASTER_TIMEOUT_EN is defined, the DUT is built with
//   TIMEOUT=16 and the timeout scenario is also run.
module tb_nasti_lite_master;

`ifdef NASTI_LITE_MASTER_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [0:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        aw_valid, aw_ready;
    logic [0:0]  aw_id;
    logic [15:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        w_valid, w_ready;
    logic [7:0]  w_data;
    logic [0:0]  w_strb;
    logic        b_valid, b_ready;
    logic [0:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [0:0]  ar_id;
    logic [15:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        r_valid, r_ready;
    logic [0:0]  r_id;
    logic [7:0]  r_data;
    logic [1:0]  r_resp;

    int checks;
    int failures;

    nasti_lite_master #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .ID_WIDTH   (1),
        .ID         (0),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .aw_id     (aw_id),
        .aw_addr   (aw_addr),
        .aw_prot   (aw_prot),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_id      (b_id),
        .b_resp    (b_resp),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_id     (ar_id),
        .ar_addr   (ar_addr),
        .ar_prot   (ar_prot),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_id      (r_id),
        .r_data    (r_data),
        .r_resp    (r_resp)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle. Inputs are then driven, and outputs sampled,
    // 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rsp_ready = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; b_id = '0; b_resp = '0;
        r_valid = 1'b0; r_id = '0; r_data = '0; r_resp = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #12;
        checks++;
        if ({cmd_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid} !== 7'b1000000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=1000000",
                     {cmd_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid});
        end
        checks++;
        if ({rsp_rdata, rsp_resp, aw_prot, ar_prot, aw_id, ar_id} !== 18'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h exp=0",
                     {rsp_rdata, rsp_resp, aw_prot, ar_prot, aw_id, ar_id});
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    // Zero-wait write: the command is accepted at T, aw/w are valid at
    // T+1, b completes at T+2 and rsp_valid is seen at T+3.
    task automatic test_write_basic();
        aw_ready = 1'b1; w_ready = 1'b1;
        b_valid = 1'b1; b_resp = 2'b00; b_id = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0004; cmd_wdata = 8'h5A; cmd_strb = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wr_cmd_ready got=%b exp=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({aw_valid, w_valid, cmd_ready, aw_addr, w_data, w_strb} !== {3'b110, 16'h0004, 8'h5A, 1'b1}) begin
            failures++;
            $display("[TB] FAIL wr_t1 got=%b%b%b %h %h %b exp=110 0004 5a 1",
                     aw_valid, w_valid, cmd_ready, aw_addr, w_data, w_strb);
        end
        tick();
        checks++;
        if ({aw_valid, w_valid, b_ready, rsp_valid} !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL wr_t2 got=%b exp=0010", {aw_valid, w_valid, b_ready, rsp_valid});
        end
        tick();
        b_valid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata, b_ready} !== {1'b1, 2'b00, 8'h00, 1'b0}) begin
            failures++;
            $display("[TB] FAIL wr_t3 got=%b %b %h %b exp=1 00 00 0", rsp_valid, rsp_resp, rsp_rdata, b_ready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL wr_done got=%b exp=01", {rsp_valid, cmd_ready});
        end
    endtask

    // Read whose AR is stalled for 5 cycles; ar_addr must not move while stalled.
    task automatic test_read_stall();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010;
        tick();
        cmd_valid = 1'b0; cmd_addr = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({ar_valid, ar_addr, r_ready} !== {1'b1, 16'h0010, 1'b0}) begin
                failures++;
                $display("[TB] FAIL rd_stall%0d got=%b %h %b exp=1 0010 0", i, ar_valid, ar_addr, r_ready);
            end
            tick();
        end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        checks++;
        if ({ar_valid, r_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rd_ar_done got=%b exp=01", {ar_valid, r_ready});
        end
        r_valid = 1'b1; r_data = 8'hC3; r_resp = 2'b00; r_id = 1'b0;
        tick();
        r_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_resp, r_ready} !== {1'b1, 8'hC3, 2'b00, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rd_rsp got=%b %h %b %b exp=1 c3 00 0", rsp_valid, rsp_rdata, rsp_resp, r_ready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Write where AW and W handshake 3 cycles apart, in the order selected by aw_first.
    task automatic test_write_split(input bit aw_first);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0020; cmd_wdata = 8'hA5; cmd_strb = 1'b1;
        tick();
        cmd_valid = 1'b0;
        aw_ready = aw_first; w_ready = !aw_first;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({aw_valid, w_valid, b_ready} !== {!aw_first, aw_first, 1'b0}) begin
                failures++;
                $display("[TB] FAIL split%0d_wait%0d got=%b exp=%b", aw_first, i,
                         {aw_valid, w_valid, b_ready}, {!aw_first, aw_first, 1'b0});
            end
            if (i < 2) tick();
        end
        aw_ready = !aw_first; w_ready = aw_first;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        checks++;
        if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL split%0d_both got=%b exp=001", aw_first, {aw_valid, w_valid, b_ready});
        end
        b_valid = 1'b1; b_resp = 2'b01;
        tick();
        b_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_resp, b_ready} !== {1'b1, 2'b01, 1'b0}) begin
            failures++;
            $display("[TB] FAIL split%0d_b got=%b %b %b exp=1 01 0", aw_first, rsp_valid, rsp_resp, b_ready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        b_resp = 2'b00;
    endtask

    // Read with a wrong r_id: the beat is still consumed and the result is SLVERR.
    // rsp_ready is already high in the r handshake cycle and must not consume
    // the response early. rsp_ready is then held low for 10 cycles.
    task automatic test_id_mismatch_and_hold();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030;
        ar_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_id = 1'b1; r_data = 8'h77; r_resp = 2'b00;
        rsp_ready = 1'b1;
        tick();
        r_valid = 1'b0; r_id = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, rsp_resp, r_ready} !== {1'b1, 2'b10, 1'b0}) begin
            failures++;
            $display("[TB] FAIL idmis_rsp got=%b %b %b exp=1 10 0", rsp_valid, rsp_resp, r_ready);
        end
        cmd_valid = 1'b1; cmd_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_rdata, rsp_resp, cmd_ready, aw_valid} !== {1'b1, 8'h77, 2'b10, 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL hold%0d got=%b %h %b %b %b exp=1 77 10 0 0", i,
                         rsp_valid, rsp_rdata, rsp_resp, cmd_ready, aw_valid);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL hold_release got=%b exp=01", {rsp_valid, cmd_ready});
        end
    endtask

    // Reset asserted while a write is pending: the valids drop without waiting for a clock edge.
    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 8'h11;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({aw_valid, w_valid} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL mid_pre got=%b exp=11", {aw_valid, w_valid});
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({aw_valid, w_valid, cmd_ready} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL mid_async got=%b exp=001", {aw_valid, w_valid, cmd_ready});
        end
        #3;
        rstn = 1'b1;
        tick();
    endtask

`ifdef NASTI_LITE_MASTER_TIMEOUT_EN
    // No b beat ever arrives: the write completes with DECERR 16 cycles after
    // entering WR_RESP. A late b beat in IDLE must then be discarded.
    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0050; cmd_wdata = 8'h22;
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if ({b_ready, rsp_valid} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL to_wait%0d got=%b exp=10", i, {b_ready, rsp_valid});
            end
            tick();
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b11, 8'h00}) begin
            failures++;
            $display("[TB] FAIL to_rsp got=%b %b %h exp=1 11 00", rsp_valid, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({b_ready, r_ready, cmd_ready} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL to_idle_ready got=%b exp=111", {b_ready, r_ready, cmd_ready});
        end
        b_valid = 1'b1; b_resp = 2'b00;
        tick();
        b_valid = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL to_late_b got=%b exp=01", {rsp_valid, cmd_ready});
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_basic();
        test_read_stall();
        test_write_split(1'b1);
        test_write_split(1'b0);
        test_id_mismatch_and_hold();
        test_reset_mid();
`ifdef NASTI_LITE_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
